// File: rtl/mem_stage.sv
// Memory stage: LDW/STW over a req/ack data port with a timeout watchdog; other opcodes pass in one negedge.
// Memory ops take 1 + ack-wait negedges (min 2); O_MemStall holds upstream for the whole access.
module mem_stage #(
   parameter int               DATA_W  = 16,
   parameter int               OPC_W   = 8,
   parameter int               ADDR_W  = 10,
   parameter int               TIMEOUT = 16,
   parameter logic [OPC_W-1:0] OP_LDW  = OPC_W'(8'h50),
   parameter logic [OPC_W-1:0] OP_STW  = OPC_W'(8'h51)
) (
   input  logic              I_CLOCK,
   input  logic              I_RESET,
   input  logic              I_LOCK,
   input  logic [DATA_W-1:0] I_ALUOut,
   input  logic [OPC_W-1:0]  I_Opcode,
   input  logic [3:0]        I_DestRegIdx,
   input  logic [DATA_W-1:0] I_DestValue,
   input  logic              I_FetchStall,
   input  logic              I_DepStall,
   input  logic              I_MemAck,
   input  logic [DATA_W-1:0] I_MemRData,
   output logic              O_MemReq,
   output logic              O_MemWe,
   output logic [ADDR_W-1:0] O_MemAddr,
   output logic [DATA_W-1:0] O_MemWData,
   output logic              O_MemStall,
   output logic              O_LOCK,
   output logic [OPC_W-1:0]  O_Opcode,
   output logic [3:0]        O_DestRegIdx,
   output logic [DATA_W-1:0] O_ALUOut,
   output logic [DATA_W-1:0] O_MemOut,
   output logic              O_FetchStall,
   output logic              O_DepStall,
   output logic              O_MemErr
);

   localparam int              CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   logic [0:0]        state_q,  state_d;
   logic [CNT_W-1:0]  cnt_q,    cnt_d;
   logic              lock_q,   lock_d;
   logic              req_q,    req_d;
   logic              we_q,     we_d;
   logic [ADDR_W-1:0] addr_q,   addr_d;
   logic [DATA_W-1:0] wdata_q,  wdata_d;
   logic              stall_q,  stall_d;
   logic [OPC_W-1:0]  opc_q,    opc_d;
   logic [3:0]        idx_q,    idx_d;
   logic [DATA_W-1:0] alu_q,    alu_d;
   logic [DATA_W-1:0] memout_q, memout_d;
   logic              fstall_q, fstall_d;
   logic              dstall_q, dstall_d;
   logic              err_q,    err_d;

   logic in_valid;
   logic in_ldw;
   logic in_stw;
   logic in_mem;
   logic addr_oor;
   logic busy_ldw;
   logic timeout_hit;

   assign in_valid    = I_LOCK & ~I_FetchStall & ~I_DepStall;
   assign in_ldw      = (I_Opcode == OP_LDW);
   assign in_stw      = (I_Opcode == OP_STW);
   assign in_mem      = in_ldw | in_stw;
   assign addr_oor    = |I_ALUOut[DATA_W-1:ADDR_W];
   assign busy_ldw    = (opc_q == OP_LDW);
   assign timeout_hit = (cnt_q == CNT_LAST);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      lock_d   = I_LOCK;
      req_d    = req_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      stall_d  = stall_q;
      opc_d    = opc_q;
      idx_d    = idx_q;
      alu_d    = alu_q;
      memout_d = memout_q;
      fstall_d = fstall_q;
      dstall_d = dstall_q;
      err_d    = err_q;

      case (state_q)
         ST_IDLE: begin
            if (!in_valid) begin
               fstall_d = I_FetchStall;
               dstall_d = I_DepStall;
            end else begin
               opc_d    = I_Opcode;
               idx_d    = I_DestRegIdx;
               alu_d    = I_ALUOut;
               fstall_d = 1'b0;
               dstall_d = 1'b0;
               if (in_mem && addr_oor) begin
                  // Out-of-range access retires immediately with no bus cycle
                  err_d = 1'b1;
                  if (in_ldw) begin
                     memout_d = '0;
                  end
               end else if (in_mem) begin
                  addr_d   = I_ALUOut[ADDR_W-1:0];
                  we_d     = in_stw;
                  if (in_stw) begin
                     wdata_d = I_DestValue;
                  end
                  req_d    = 1'b1;
                  stall_d  = 1'b1;
                  dstall_d = 1'b1;
                  cnt_d    = '0;
                  state_d  = ST_BUSY;
               end
            end
         end

         ST_BUSY: begin
            if (I_MemAck || timeout_hit) begin
               // Ack takes priority over a coincident timeout
               if (busy_ldw) begin
                  memout_d = I_MemAck ? I_MemRData : '0;
               end
               if (!I_MemAck) begin
                  err_d = 1'b1;
               end
               fstall_d = 1'b0;
               dstall_d = 1'b0;
               req_d    = 1'b0;
               we_d     = 1'b0;
               stall_d  = 1'b0;
               state_d  = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(negedge I_CLOCK or posedge I_RESET) begin
      if (I_RESET) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         lock_q   <= 1'b0;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         stall_q  <= 1'b0;
         opc_q    <= '0;
         idx_q    <= '0;
         alu_q    <= '0;
         memout_q <= '0;
         fstall_q <= 1'b0;
         dstall_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         lock_q   <= lock_d;
         req_q    <= req_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         stall_q  <= stall_d;
         opc_q    <= opc_d;
         idx_q    <= idx_d;
         alu_q    <= alu_d;
         memout_q <= memout_d;
         fstall_q <= fstall_d;
         dstall_q <= dstall_d;
         err_q    <= err_d;
      end
   end

   assign O_MemReq     = req_q;
   assign O_MemWe      = we_q;
   assign O_MemAddr    = addr_q;
   assign O_MemWData   = wdata_q;
   assign O_MemStall   = stall_q;
   assign O_LOCK       = lock_q;
   assign O_Opcode     = opc_q;
   assign O_DestRegIdx = idx_q;
   assign O_ALUOut     = alu_q;
   assign O_MemOut     = memout_q;
   assign O_FetchStall = fstall_q;
   assign O_DepStall   = dstall_q;
   assign O_MemErr     = err_q;

   a_we_needs_req: assert property (@(negedge I_CLOCK) disable iff (I_RESET) O_MemWe |-> O_MemReq);
   a_stall_is_req: assert property (@(negedge I_CLOCK) disable iff (I_RESET) O_MemStall == O_MemReq);

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: vector table through a commit scoreboard, plus reset/ack/lock corner sequences.
module tb_mem_stage;
   localparam int DATA_W  = 16;
   localparam int OPC_W   = 8;
   localparam int ADDR_W  = 10;
   localparam int TIMEOUT = 16;
   localparam logic [7:0] OP_ADD = 8'h01;
   localparam logic [7:0] OP_SUB = 8'h02;
   localparam logic [7:0] OP_LDW = 8'h50;
   localparam logic [7:0] OP_STW = 8'h51;

   logic              I_CLOCK, I_RESET, I_LOCK, I_FetchStall, I_DepStall, I_MemAck;
   logic [DATA_W-1:0] I_ALUOut, I_DestValue, I_MemRData;
   logic [OPC_W-1:0]  I_Opcode;
   logic [3:0]        I_DestRegIdx;
   logic              O_MemReq, O_MemWe, O_MemStall, O_LOCK, O_FetchStall, O_DepStall, O_MemErr;
   logic [ADDR_W-1:0] O_MemAddr;
   logic [DATA_W-1:0] O_MemWData, O_ALUOut, O_MemOut;
   logic [OPC_W-1:0]  O_Opcode;
   logic [3:0]        O_DestRegIdx;

   mem_stage #(.DATA_W(DATA_W), .OPC_W(OPC_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT),
               .OP_LDW(OP_LDW), .OP_STW(OP_STW)) dut (
      .I_CLOCK(I_CLOCK), .I_RESET(I_RESET), .I_LOCK(I_LOCK), .I_ALUOut(I_ALUOut),
      .I_Opcode(I_Opcode), .I_DestRegIdx(I_DestRegIdx), .I_DestValue(I_DestValue),
      .I_FetchStall(I_FetchStall), .I_DepStall(I_DepStall), .I_MemAck(I_MemAck),
      .I_MemRData(I_MemRData), .O_MemReq(O_MemReq), .O_MemWe(O_MemWe), .O_MemAddr(O_MemAddr),
      .O_MemWData(O_MemWData), .O_MemStall(O_MemStall), .O_LOCK(O_LOCK), .O_Opcode(O_Opcode),
      .O_DestRegIdx(O_DestRegIdx), .O_ALUOut(O_ALUOut), .O_MemOut(O_MemOut),
      .O_FetchStall(O_FetchStall), .O_DepStall(O_DepStall), .O_MemErr(O_MemErr));

   typedef struct {
      logic [7:0]  opc;
      logic [15:0] alu;
      logic [3:0]  idx;
      logic [15:0] wdat;
      int          delay;     // sample index at which memory acks; 0 = never
      logic [15:0] rdat;
      logic [15:0] exp_mem;   // O_MemOut after commit
      logic        exp_err;   // O_MemErr after commit (sticky)
      int          exp_stall; // cycles with O_MemStall / O_MemReq high
   } vec_t;

   typedef struct {
      logic [7:0]  opc;
      logic [3:0]  idx;
      logic [15:0] alu;
      logic [15:0] mem;
      logic        err;
   } exp_t;

   exp_t        sb_q[$];
   vec_t        vecs[10];
   vec_t        post_rst;
   int          n_cmp = 0;
   int          n_bad = 0;
   bit          sb_en = 0;
   int          mem_cnt = 0;
   int          mem_delay = 0;
   int          stall_cnt = 0;
   int          req_cnt = 0;
   logic [15:0] mem_rdata = '0;
   logic        cur_we = 0;
   logic [9:0]  cur_addr = '0;
   logic [15:0] cur_wd = '0;

   initial I_CLOCK = 1'b0;
   always #5 I_CLOCK = ~I_CLOCK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got running want finished");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // One cycle: sample after posedge, check commits, then play the memory responder.
   task automatic clk_step();
      exp_t e;
      @(posedge I_CLOCK);
      #1;
      if (I_RESET) begin
         sb_en    = 0;
         I_MemAck = 1'b0;
         mem_cnt  = 0;
         return;
      end
      if (O_MemStall) stall_cnt++;
      if (O_MemReq)   req_cnt++;
      if (O_FetchStall) begin
         sb_en = 1;
      end else if (sb_en && !O_DepStall) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_commit: got opcode %h want no commit", O_Opcode);
         end else begin
            e = sb_q.pop_front();
            chk("commit_opcode", 32'(O_Opcode), 32'(e.opc));
            chk("commit_idx",    32'(O_DestRegIdx), 32'(e.idx));
            chk("commit_alu",    32'(O_ALUOut), 32'(e.alu));
            chk("commit_memout", 32'(O_MemOut), 32'(e.mem));
            chk("commit_err",    32'(O_MemErr), 32'(e.err));
         end
      end
      if (O_MemReq && !I_MemAck) begin
         mem_cnt++;
         if (mem_cnt == 1) begin
            chk("req_we",   32'(O_MemWe), 32'(cur_we));
            chk("req_addr", 32'(O_MemAddr), 32'(cur_addr));
            if (cur_we) chk("req_wdata", 32'(O_MemWData), 32'(cur_wd));
         end
         if (mem_delay != 0 && mem_cnt == mem_delay) begin
            I_MemAck   = 1'b1;
            I_MemRData = mem_rdata;
         end
      end else begin
         I_MemAck = 1'b0;
         mem_cnt  = 0;
      end
   endtask

   task automatic run_vec(input vec_t v);
      exp_t e;
      int   guard;
      I_LOCK       = 1'b1;
      I_FetchStall = 1'b0;
      I_DepStall   = 1'b0;
      I_Opcode     = v.opc;
      I_ALUOut     = v.alu;
      I_DestRegIdx = v.idx;
      I_DestValue  = v.wdat;
      mem_delay    = v.delay;
      mem_rdata    = v.rdat;
      cur_we       = (v.opc == OP_STW);
      cur_addr     = v.alu[9:0];
      cur_wd       = v.wdat;
      e.opc = v.opc; e.idx = v.idx; e.alu = v.alu; e.mem = v.exp_mem; e.err = v.exp_err;
      sb_q.push_back(e);
      stall_cnt = 0;
      req_cnt   = 0;
      clk_step();
      guard = 0;
      while (O_MemStall && guard < 64) begin
         clk_step();
         guard++;
      end
      chk("stall_cycles", 32'(stall_cnt), 32'(v.exp_stall));
      chk("req_cycles",   32'(req_cnt), 32'(v.exp_stall));
      chk("commit_done",  32'(sb_q.size()), 32'd0);
      I_FetchStall = 1'b1;
   endtask

   initial begin
      vecs[0] = '{OP_ADD, 16'h0005, 4'd3,  16'h0000, 0,  16'h0000, 16'h0000, 1'b0, 0};
      vecs[1] = '{OP_LDW, 16'h0010, 4'd5,  16'h0000, 3,  16'hBEEF, 16'hBEEF, 1'b0, 3};
      vecs[2] = '{OP_STW, 16'h0020, 4'd0,  16'h1234, 1,  16'h0000, 16'hBEEF, 1'b0, 1};
      vecs[3] = '{OP_SUB, 16'h1234, 4'd7,  16'h0000, 0,  16'h0000, 16'hBEEF, 1'b0, 0};
      vecs[4] = '{OP_LDW, 16'h03FF, 4'd2,  16'h0000, 16, 16'hA5A5, 16'hA5A5, 1'b0, 16};
      vecs[5] = '{OP_LDW, 16'h0011, 4'd1,  16'h0000, 0,  16'h5555, 16'h0000, 1'b1, 16};
      vecs[6] = '{OP_LDW, 16'h8000, 4'd4,  16'h0000, 1,  16'h6666, 16'h0000, 1'b1, 0};
      vecs[7] = '{OP_LDW, 16'h0012, 4'd6,  16'h0000, 2,  16'h7777, 16'h7777, 1'b1, 2};
      vecs[8] = '{OP_STW, 16'h0400, 4'd8,  16'hFFFF, 1,  16'h0000, 16'h7777, 1'b1, 0};
      vecs[9] = '{OP_ADD, 16'hFFFF, 4'd15, 16'h0000, 0,  16'h0000, 16'h7777, 1'b1, 0};
      post_rst = '{OP_ADD, 16'h0042, 4'd9, 16'h0000, 0,  16'h0000, 16'h0000, 1'b0, 0};

      I_RESET = 1'b1; I_LOCK = 1'b1; I_FetchStall = 1'b1; I_DepStall = 1'b0;
      I_ALUOut = '0; I_Opcode = '0; I_DestRegIdx = '0; I_DestValue = '0;
      I_MemAck = 1'b0; I_MemRData = '0;
      repeat (2) @(posedge I_CLOCK);
      #1;
      chk("reset_ctrl", 32'({O_MemReq, O_MemWe, O_MemStall, O_LOCK, O_FetchStall, O_DepStall, O_MemErr}), 32'd0);
      chk("reset_data", {O_ALUOut, O_MemOut}, 32'd0);
      chk("reset_misc", 32'({O_Opcode, O_DestRegIdx, O_MemAddr, O_MemWData}), 32'd0);
      I_RESET = 1'b0;
      clk_step();
      chk("lock_follow_hi", 32'(O_LOCK), 32'd1);

      for (int i = 0; i < 10; i++) run_vec(vecs[i]);

      // Invalid input forwards the bubble markers and holds the payload
      I_FetchStall = 1'b0; I_DepStall = 1'b1;
      clk_step();
      chk("fwd_depstall",   32'({O_FetchStall, O_DepStall}), 32'b01);
      chk("hold_alu",       32'(O_ALUOut), 32'h0000FFFF);
      I_LOCK = 1'b0; I_FetchStall = 1'b1; I_DepStall = 1'b0;
      clk_step();
      chk("lock_follow_lo", 32'(O_LOCK), 32'd0);
      chk("fwd_fetchstall", 32'({O_FetchStall, O_DepStall}), 32'b10);
      I_LOCK = 1'b1;

      // Stray ack while idle must do nothing
      I_MemAck = 1'b1; I_MemRData = 16'h1111;
      @(negedge I_CLOCK);
      #1;
      chk("idle_ack_req",    32'({O_MemReq, O_MemStall}), 32'd0);
      chk("idle_ack_memout", 32'(O_MemOut), 32'h00007777);
      I_MemAck = 1'b0;
      clk_step();

      // Reset in the middle of an access
      I_FetchStall = 1'b0; I_Opcode = OP_LDW; I_ALUOut = 16'h0030; I_DestRegIdx = 4'd2;
      mem_delay = 0; cur_we = 1'b0; cur_addr = 10'h030;
      repeat (3) clk_step();
      chk("busy_req_stall", 32'({O_MemReq, O_MemStall}), 32'b11);
      #2;
      I_RESET = 1'b1;
      #1;
      chk("rst_busy_req_stall", 32'({O_MemReq, O_MemStall}), 32'd0);
      chk("rst_busy_err_dep",   32'({O_MemErr, O_DepStall}), 32'd0);
      I_FetchStall = 1'b1;
      clk_step();
      I_RESET = 1'b0;
      clk_step();
      run_vec(post_rst);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
